// File: rtl/sseg_apb_ctrl_pkg.sv
// Shared constants for the APB seven-segment scan controller: register map, CTRL
// field positions, display source encodings and the active-low glyph table.
package sseg_apb_ctrl_pkg;

  localparam logic [7:0] OffCtrl   = 8'h00;
  localparam logic [7:0] OffValue  = 8'h04;
  localparam logic [7:0] OffPeriod = 8'h08;
  localparam logic [7:0] OffStatus = 8'h0C;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlSrcLsb   = 1;
  localparam int unsigned CtrlAutoBit  = 3;
  localparam int unsigned CtrlBlankLsb = 4;
  localparam int unsigned CtrlRotLsb   = 8;

  localparam int unsigned PeriodMin = 16;

  typedef enum logic [1:0] {
    SrcAddr  = 2'd0,
    SrcData  = 2'd1,
    SrcIn    = 2'd2,
    SrcValue = 2'd3
  } src_e;

  // Segments {a,b,c,d,e,f,g}, a = MSB, 0 = lit; entry 15 (F) first.
  localparam logic [15:0][6:0] GlyphTbl = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  // Auto rotation cycles the three hex sources and never lands on VALUE.
  function automatic src_e next_auto_src(src_e cur);
    unique case (cur)
      SrcAddr: return SrcData;
      SrcData: return SrcIn;
      default: return SrcAddr;
    endcase
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module sseg_hex_decode
  import sseg_apb_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = GlyphTbl[nibble_i];

endmodule

// File: rtl/sseg_apb_ctrl.sv
// APB-programmable four-digit multiplexed hex display driver with per-frame
// source shadowing, optional automatic source rotation and digit blanking.
module sseg_apb_ctrl
  import sseg_apb_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_W   = 21,
  parameter int unsigned PERIOD_RST = 400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic [15:0] src0,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  output logic [3:0]  enable,
  output logic [6:0]  LED_out
);

  logic [15:0]         ctrl_q, ctrl_d;
  logic [15:0]         value_q, value_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [15:0]         shadow_q, shadow_d;
  logic [PERIOD_W-1:0] tick_q, tick_d;
  logic [1:0]          digit_q, digit_d;
  logic [7:0]          frame_q, frame_d;
  logic [7:0]          rot_q, rot_d;
  src_e                cur_src_q, cur_src_d;

  logic        access, addr_hit, bad, wr_ok, boundary;
  logic        wr_ctrl, wr_value, wr_period;
  logic [7:0]  reg_addr;
  logic [31:0] rdata;
  logic [PERIOD_W-1:0] period_wval;

  logic       en, auto_en;
  src_e       src_sel;
  logic [3:0] blank;
  logic [7:0] rot_frames;
  logic [3:0] nibble;
  logic [6:0] seg;
  logic       unused_apb;

  assign en         = ctrl_q[CtrlEnBit];
  assign auto_en    = ctrl_q[CtrlAutoBit];
  assign src_sel    = src_e'(ctrl_q[CtrlSrcLsb +: 2]);
  assign blank      = ctrl_q[CtrlBlankLsb +: 4];
  assign rot_frames = ctrl_q[CtrlRotLsb +: 8];

  assign reg_addr = {paddr[7:2], 2'b00};
  assign access   = psel & penable;
  assign addr_hit = (reg_addr == OffCtrl) | (reg_addr == OffValue) |
                    (reg_addr == OffPeriod) | (reg_addr == OffStatus);
  assign bad      = access & (~addr_hit | (pwrite & (reg_addr == OffStatus)));
  assign wr_ok    = access & pwrite & ~bad;
  assign wr_ctrl   = wr_ok & (reg_addr == OffCtrl);
  assign wr_value  = wr_ok & (reg_addr == OffValue);
  assign wr_period = wr_ok & (reg_addr == OffPeriod);

  assign unused_apb = ^{paddr[1:0], pwdata[31:16]};

  always_comb begin
    rdata = '0;
    case (reg_addr)
      OffCtrl:   rdata = {16'h0, ctrl_q};
      OffValue:  rdata = {16'h0, value_q};
      OffPeriod: rdata = 32'(period_q);
      OffStatus: rdata = {16'h0, frame_q, 4'h0, cur_src_q, digit_q};
      default:   rdata = '0;
    endcase
  end

  // Bus outputs are gated by reset so an in-flight access reads as idle.
  assign pready  = access & rst_n;
  assign pslverr = bad & rst_n;
  assign prdata  = (access & ~pwrite & ~bad & rst_n) ? rdata : '0;

  assign period_wval = pwdata[PERIOD_W-1:0];

  always_comb begin
    ctrl_d   = ctrl_q;
    value_d  = value_q;
    period_d = period_q;
    if (wr_ctrl)  ctrl_d  = pwdata[15:0];
    if (wr_value) value_d = pwdata[15:0];
    if (wr_period) begin
      period_d = (period_wval < PERIOD_W'(PeriodMin)) ? PERIOD_W'(PeriodMin) : period_wval;
    end
  end

  // Scan timing and frame-boundary bookkeeping all use pre-write register values.
  always_comb begin
    tick_d    = tick_q;
    digit_d   = digit_q;
    frame_d   = frame_q;
    rot_d     = rot_q;
    cur_src_d = cur_src_q;
    shadow_d  = shadow_q;
    boundary  = 1'b0;

    if (!en) begin
      tick_d  = '0;
      digit_d = '0;
      frame_d = '0;
    end else if (wr_period) begin
      tick_d = '0;
    end else if (tick_q == period_q - PERIOD_W'(1)) begin
      tick_d   = '0;
      digit_d  = digit_q + 2'd1;
      boundary = (digit_q == 2'd3);
    end else begin
      tick_d = tick_q + PERIOD_W'(1);
    end

    if (!en || !auto_en) rot_d = '0;

    if (boundary) begin
      frame_d = frame_q + 8'd1;
      if (!auto_en) begin
        cur_src_d = src_sel;
      end else if (rot_frames != 8'd0) begin
        if (rot_q >= rot_frames - 8'd1) begin
          rot_d     = '0;
          cur_src_d = next_auto_src(cur_src_q);
        end else begin
          rot_d = rot_q + 8'd1;
        end
      end
      unique case (cur_src_d)
        SrcAddr:  shadow_d = src0;
        SrcData:  shadow_d = src1;
        SrcIn:    shadow_d = src2;
        SrcValue: shadow_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      value_q   <= '0;
      period_q  <= PERIOD_W'(PERIOD_RST);
      shadow_q  <= '0;
      tick_q    <= '0;
      digit_q   <= '0;
      frame_q   <= '0;
      rot_q     <= '0;
      cur_src_q <= SrcAddr;
    end else begin
      ctrl_q    <= ctrl_d;
      value_q   <= value_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      tick_q    <= tick_d;
      digit_q   <= digit_d;
      frame_q   <= frame_d;
      rot_q     <= rot_d;
      cur_src_q <= cur_src_d;
    end
  end

  assign nibble = shadow_q[{digit_q, 2'b00} +: 4];

  sseg_hex_decode u_hex_decode (
    .nibble_i(nibble),
    .seg_o   (seg)
  );

  assign enable  = en ? (~(4'b0001 << digit_q) | blank) : 4'b1111;
  assign LED_out = en ? seg : 7'b1111111;

endmodule

// File: tb/tb_sseg_apb_ctrl.sv
// Randomized and directed bench for sseg_apb_ctrl against a cycle-level reference model.
module tb_sseg_apb_ctrl;

  localparam int PW = 21;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [15:0] src0 = '0, src1 = '0, src2 = '0;
  logic [3:0]  enable;
  logic [6:0]  LED_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sseg_apb_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .src0   (src0),
    .src1   (src1),
    .src2   (src2),
    .enable (enable),
    .LED_out(LED_out)
  );

  // Reference model state
  logic [15:0] m_ctrl, m_value, m_shadow;
  int m_period, m_tick, m_digit, m_frame, m_src, m_rot;

  // Lit segments per hex glyph, by letter name
  string glyph_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                             "aefg"};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(int n);
    logic [6:0] s;
    string g;
    s = 7'h7F;
    g = glyph_segs[n];
    for (int i = 0; i < g.len(); i++) s[6 - (int'(g[i]) - 97)] = 1'b0;
    return s;
  endfunction

  function automatic void model_reset();
    m_ctrl = '0; m_value = '0; m_shadow = '0;
    m_period = 400000; m_tick = 0; m_digit = 0; m_frame = 0; m_src = 0; m_rot = 0;
  endfunction

  function automatic logic [31:0] reg_read(int w);
    case (w)
      0: return {16'h0, m_ctrl};
      1: return {16'h0, m_value};
      2: return 32'(m_period);
      3: return {16'h0, 8'(m_frame), 4'h0, 2'(m_src), 2'(m_digit)};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] src_val(int s);
    case (s)
      0: return src0;
      1: return src1;
      2: return src2;
      default: return m_value;
    endcase
  endfunction

  function automatic logic [3:0] exp_enable();
    logic [3:0] e;
    e = 4'hF;
    if (m_ctrl[0]) for (int d = 0; d < 4; d++) e[d] = (d != m_digit) || m_ctrl[4 + d];
    return e;
  endfunction

  function automatic logic [6:0] exp_led();
    if (!m_ctrl[0]) return 7'h7F;
    return glyph(int'((m_shadow >> (4 * m_digit)) & 16'hF));
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  function automatic void model_step();
    bit acc, bad, wr, bnd, en, autob;
    int w, rot, v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = psel && penable;
    w = int'(paddr[7:2]);
    bad = acc && (w > 3 || (pwrite && w == 3));
    wr = acc && pwrite && !bad;
    en = m_ctrl[0];
    autob = m_ctrl[3];
    rot = int'(m_ctrl[15:8]);
    bnd = 0;
    if (!en) begin
      m_tick = 0; m_digit = 0; m_frame = 0;
    end else if (wr && w == 2) begin
      m_tick = 0;
    end else begin
      m_tick++;
      if (m_tick == m_period) begin
        m_tick = 0;
        m_digit = (m_digit + 1) % 4;
        bnd = (m_digit == 0);
      end
    end
    if (!en || !autob) m_rot = 0;
    if (bnd) begin
      m_frame = (m_frame + 1) % 256;
      if (!autob) m_src = int'(m_ctrl[2:1]);
      else if (rot > 0) begin
        m_rot++;
        if (m_rot >= rot) begin
          m_rot = 0;
          m_src = (m_src >= 2) ? 0 : m_src + 1;
        end
      end
      m_shadow = src_val(m_src);
    end
    if (wr) begin
      case (w)
        0: m_ctrl = pwdata[15:0];
        1: m_value = pwdata[15:0];
        2: begin
          v = int'(pwdata[PW-1:0]);
          m_period = (v < 16) ? 16 : v;
        end
        default: ;
      endcase
    end
  endfunction

  // Called at a falling edge with inputs applied; checks outputs, then runs one clock.
  task automatic step();
    logic acc, bad;
    int w;
    if (!rst_n) model_reset();
    #1;
    acc = psel && penable && rst_n;
    w = int'(paddr[7:2]);
    bad = acc && (w > 3 || (pwrite && w == 3));
    check_eq("prdata", prdata, (acc && !pwrite && !bad) ? reg_read(w) : 32'h0);
    check_eq("pslverr", {31'h0, pslverr}, {31'h0, bad});
    check_eq("pready", {31'h0, pready}, {31'h0, acc});
    check_eq("enable", {28'h0, enable}, {28'h0, exp_enable()});
    check_eq("led", {25'h0, LED_out}, {25'h0, exp_led()});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    #1;
    rd = prdata;
    err = pslverr;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wait_frame();
    int f0, n;
    f0 = m_frame;
    n = 0;
    while (m_frame == f0 && n < 400) begin
      step();
      n++;
    end
    if (m_frame == f0) check_eq("frame_wait", n, 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [3:0]  an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0]  seg_exp [4] = '{7'h60, 7'h08, 7'h12, 7'h4F};
  int          src_seq [7] = '{0, 0, 1, 1, 2, 2, 0};

  initial begin
    int n, a, w;
    logic [31:0] d;
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // Reset values
    apb_xfer(1'b0, 8'h08, 32'h0, rd, er);
    check_eq("rst_period", rd, 32'd400000);
    apb_xfer(1'b0, 8'h00, 32'h0, rd, er);
    check_eq("rst_ctrl", rd, 32'h0);
    check_eq("rst_enable", {28'h0, enable}, 32'hF);
    check_eq("rst_led", {25'h0, LED_out}, 32'h7F);

    // Basic scan, PERIOD clamped up to 16
    src0 = 16'h5555; src1 = 16'h12AB; src2 = 16'h9C0E;
    apb_xfer(1'b1, 8'h08, 32'd5, rd, er);
    apb_xfer(1'b0, 8'h08, 32'h0, rd, er);
    check_eq("period_clamp", rd, 32'd16);
    apb_xfer(1'b1, 8'h00, 32'h0003, rd, er);
    wait_frame();
    for (int i = 0; i < 64; i++) begin
      check_eq("scan_an", {28'h0, enable}, {28'h0, an_exp[i / 16]});
      check_eq("scan_seg", {25'h0, LED_out}, {25'h0, seg_exp[i / 16]});
      step();
    end

    // Error responses
    apb_xfer(1'b1, 8'h00, 32'h0, rd, er);
    apb_xfer(1'b0, 8'h0C, 32'h0, rd, er);
    check_eq("status_idle", rd, 32'h4);
    apb_xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, rd, er);
    check_eq("status_wr_err", {31'h0, er}, 32'h1);
    apb_xfer(1'b0, 8'h0C, 32'h0, rd, er);
    check_eq("status_kept", rd, 32'h4);
    apb_xfer(1'b0, 8'h10, 32'h0, rd, er);
    check_eq("unmapped_err", {31'h0, er}, 32'h1);
    check_eq("unmapped_rd", rd, 32'h0);

    // Auto rotation every two frames
    reset_pulse();
    apb_xfer(1'b1, 8'h08, 32'd16, rd, er);
    apb_xfer(1'b1, 8'h00, 32'h0209, rd, er);
    for (int f = 0; f < 7; f++) begin
      apb_xfer(1'b0, 8'h0C, 32'h0, rd, er);
      check_eq("auto_src", {30'h0, rd[3:2]}, src_seq[f]);
      wait_frame();
    end

    // SRC change landing on the boundary edge applies one frame later
    reset_pulse();
    src0 = 16'h1111; src2 = 16'h2222;
    apb_xfer(1'b1, 8'h08, 32'd16, rd, er);
    apb_xfer(1'b1, 8'h00, 32'h0001, rd, er);
    n = 0;
    while (!(m_digit == 3 && m_tick == m_period - 2) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check_eq("align_wait", n, 0);
    apb_xfer(1'b1, 8'h00, 32'h0005, rd, er);
    check_eq("hold_seg", {25'h0, LED_out}, 32'h4F);
    apb_xfer(1'b0, 8'h0C, 32'h0, rd, er);
    check_eq("hold_src", {30'h0, rd[3:2]}, 32'h0);
    wait_frame();
    check_eq("new_seg", {25'h0, LED_out}, 32'h12);
    apb_xfer(1'b0, 8'h0C, 32'h0, rd, er);
    check_eq("new_src", {30'h0, rd[3:2]}, 32'h2);

    // Reset mid-frame and mid-transfer with BLANK = 0101
    apb_xfer(1'b1, 8'h00, 32'h0051, rd, er);
    repeat (40) step();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hBEEF;
    step();
    penable = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_an", {28'h0, enable}, 32'hF);
    check_eq("rstmid_led", {25'h0, LED_out}, 32'h7F);
    check_eq("rstmid_err", {31'h0, pslverr}, 32'h0);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    step();
    rst_n = 1'b1;
    apb_xfer(1'b0, 8'h04, 32'h0, rd, er);
    check_eq("aborted_wr", rd, 32'h0);
    apb_xfer(1'b1, 8'h00, 32'h0001, rd, er);
    check_eq("first_digit", {28'h0, enable}, 32'hE);

    // Randomized traffic
    apb_xfer(1'b1, 8'h08, 32'd16, rd, er);
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        src0 = 16'($urandom); src1 = 16'($urandom); src2 = 16'($urandom);
      end
      repeat ($urandom_range(0, 3)) step();
      w = $urandom_range(0, 6);
      a = (w == 6) ? $urandom_range(0, 255) : (w * 4 + $urandom_range(0, 3));
      d = $urandom;
      if (a[7:2] == 6'd0) begin
        d[0] = ($urandom_range(0, 7) != 0);
        d[15:8] = 8'($urandom_range(0, 3));
      end else if (a[7:2] == 6'd2) begin
        d = $urandom_range(0, 40);
      end
      apb_xfer(1'($urandom_range(0, 1)), 8'(a), d, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
